// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and the funct3 legality helper.
// Optional feature macro used by lsu_ctrl: LSU_TIMEOUT_EN.
package lsu_ctrl_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes (share encodings with the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Stores only know SB/SH/SW; loads additionally have the unsigned forms.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    if (!we) ok = ok || (funct3 == F3_LBU) || (funct3 == F3_LHU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and lane replication,
// load shift and sign/zero extension, and the alignment check.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Store lanes and alignment, keyed on the access size in funct3[1:0]
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned, which would otherwise infer a latch.
    be          = 4'b1111;
    wdata_lanes = wdata;
    misaligned  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be          = 4'b0001 << addr;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << addr;
        wdata_lanes = {2{wdata[15:0]}};
        misaligned  = addr[0];
      end
      default: misaligned = |addr;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted  = rdata >> {addr, 3'b000};
    load_ext = '0;
    case (funct3)
      F3_LB:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_ext = shifted;
      F3_LBU:  load_ext = {24'h0, shifted[7:0]};
      F3_LHU:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port.
// Single outstanding access: IDLE -> REQ -> WAIT -> RESP, or IDLE -> RESP
// for illegal accesses. Define LSU_TIMEOUT_EN to bound the WAIT state.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // The counter must be able to represent the timeout value.
  if ((1 << TO_W) <= TIMEOUT_CYCLES) begin : g_to_w_check
    $error("lsu_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [29:0] word_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  a_funct3;
  logic [1:0]  a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata_lanes;
  logic [31:0] a_load_ext;
  logic        a_misaligned;
  logic        legal;
  logic        to_expired;

  // In IDLE the lane logic looks at the incoming request; afterwards it
  // works on the captured access so load data can be extended in WAIT.
  assign a_funct3 = (state_q == IDLE) ? req_funct3    : funct3_q;
  assign a_addr   = (state_q == IDLE) ? req_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3      (a_funct3),
    .addr        (a_addr),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (a_be),
    .wdata_lanes (a_wdata_lanes),
    .load_ext    (a_load_ext),
    .misaligned  (a_misaligned)
  );

  assign legal = funct3_legal(req_we, req_funct3) && !a_misaligned;

`ifdef LSU_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;

  // Count idle WAIT cycles; cleared as the grant moves us into WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_q == REQ && mem_gnt) begin
      to_cnt <= '0;
    end else if (state_q == WAIT && !mem_rvalid) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Expires on the WAIT cycle whose increment would reach the limit
  assign to_expired = (state_q == WAIT) && !mem_rvalid && (to_cnt == TO_LAST);
`else
  assign to_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_rvalid takes priority over timeout expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = legal ? REQ : RESP;
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid)      state_d = RESP;
        else if (to_expired) state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access capture on accept and result capture at the end of WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      word_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          funct3_q <= req_funct3;
          off_q    <= req_addr[1:0];
          word_q   <= req_addr[31:2];
          be_q     <= req_we ? a_be : 4'b1111;
          wdata_q  <= req_we ? a_wdata_lanes : '0;
          rdata_q  <= '0;
          err_q    <= !legal;
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= we_q ? '0 : a_load_ext;
          end else if (to_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {word_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the stimulus process plays execute stage
// and memory, pushing each expected response; a monitor pops and compares
// on every response handshake. Timeout tests run when LSU_TIMEOUT_EN is set.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int LONG_WAIT = 2;
`else
  localparam int LONG_WAIT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {47'h0, rsp_rdata, rsp_err}, 80'h0);
        n_fail++;
        $display("FAIL rsp_unexpected: response with empty scoreboard");
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp", {47'h0, rsp_rdata, rsp_err}, {47'h0, e.rdata, e.err});
      end
    end
  end

  // One access, entered and left just after a rising edge. Stalls:
  // gnt_dly cycles without grant, rv_dly WAIT cycles, rdy_dly cycles of
  // rsp_ready low.
  task automatic access(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic legal,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rsp, input int gnt_dly,
                        input int rv_dly, input int rdy_dly);
    logic [79:0] exp_mem;
    exp_q.push_back('{rdata: exp_rsp, err: !legal});
    exp_mem = {10'h0, 1'b1, we, exp_be, addr[31:2], 2'b00, (we ? exp_wdata : 32'h0)};
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    @(negedge clk) check({name, "_ready"}, {79'h0, req_ready}, 80'h1);
    @(posedge clk) #1;
    req_valid = 1'b0; req_wdata = 32'h5A5A_5A5A;
    if (legal) begin
      for (int i = 0; i < gnt_dly; i++) begin
        mem_rvalid = (i == 1);
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk) check({name, "_mem_hold"},
                             {10'h0, mem_req, mem_we, mem_be, mem_addr, (we ? mem_wdata : 32'h0)}, exp_mem);
        @(posedge clk) #1;
      end
      mem_rvalid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk) check({name, "_mem"},
                           {10'h0, mem_req, mem_we, mem_be, mem_addr, (we ? mem_wdata : 32'h0)}, exp_mem);
      @(posedge clk) #1;
      mem_gnt = 1'b0;
      for (int i = 0; i < rv_dly; i++) begin
        @(negedge clk) check({name, "_wait"}, {78'h0, mem_req, rsp_valid}, 80'h0);
        @(posedge clk) #1;
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk) check({name, "_req_drop"}, {79'h0, mem_req}, 80'h0);
      @(posedge clk) #1;
      mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_0000;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      rsp_ready = (i == rdy_dly);
      @(negedge clk);
      if (i == 0) check({name, "_rsp_valid"}, {78'h0, rsp_valid, mem_req}, 80'h2);
      if (i < rdy_dly)
        check({name, "_rsp_hold"}, {44'h0, rsp_valid, rsp_err, rsp_rdata, req_ready, busy},
              {44'h0, 1'b1, !legal, exp_rsp, 1'b0, 1'b1});
      @(posedge clk) #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    check("reset_ctrl", {73'h0, req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err, 1'b0}, 80'h40);
    check("reset_data", {12'h0, mem_be, mem_addr, mem_wdata}, 80'h0);
    check("reset_rdata", {48'h0, rsp_rdata}, 80'h0);
    @(posedge clk) #1 rst_n = 1'b1;
    @(posedge clk) #1;

    //     name     we  f3      addr          wdata          rdata          legal be       exp_wdata      exp_rsp        g  rv  rdy
    access("lb",   0, F3_LB,  32'h0000_1003, 32'h0,         32'h8022_3344, 1, 4'b1111, 32'h0,         32'hFFFF_FF80, 0, 0, 0);
    access("lhu",  0, F3_LHU, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 1, 4'b1111, 32'h0,         32'h0000_BEEF, 0, 0, 0);
    access("sh",   1, F3_SH,  32'h0000_3002, 32'h0000_ABCD, 32'h1111_1111, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,         0, 0, 0);
    access("lw_mis",0,F3_LW,  32'h0000_4001, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 0);
    access("ld011",0, 3'b011, 32'h0000_5000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 0);
    access("sb",   1, F3_SB,  32'h0000_6001, 32'h1234_5678, 32'h0,         1, 4'b0010, 32'h7878_7878, 32'h0,         5, 0, 0);
    access("lh",   0, F3_LH,  32'h0000_7002, 32'h0,         32'h8001_0000, 1, 4'b1111, 32'h0,         32'hFFFF_8001, 0, LONG_WAIT, 3);
    access("sw",   1, F3_SW,  32'h0000_8000, 32'hDEAD_BEEF, 32'h0,         1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1, 1, 0);
    access("st100",1, 3'b100, 32'h0000_9000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 2);
    access("lbu",  0, F3_LBU, 32'h0000_A001, 32'h0,         32'h0000_F700, 1, 4'b1111, 32'h0,         32'h0000_00F7, 0, 0, 0);
    access("sh_mis",1,F3_SH,  32'h0000_B001, 32'h0000_1234, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 0);

    // Reset during WAIT: abandon at once, no response
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h0000_C000;
    rsp_ready = 1'b1;
    @(posedge clk) #1 req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk) #1 mem_gnt = 1'b0;
    @(negedge clk) check("rst_wait_busy", {79'h0, busy}, 80'h1);
    #2 rst_n = 1'b0;
    #1 check("rst_abandon", {76'h0, busy, rsp_valid, req_ready, mem_req}, 80'h2);
    @(posedge clk) #1 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk) check("rst_no_rsp", {78'h0, rsp_valid, busy}, 80'h0);
    @(posedge clk) #1 mem_rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // Timeout: rvalid never arrives, error after four WAIT cycles
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h0000_D000;
    rsp_ready = 1'b1;
    @(posedge clk) #1 req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk) #1 mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) check("to_wait", {79'h0, rsp_valid}, 80'h0);
      @(posedge clk) #1;
    end
    @(negedge clk) check("to_expire", {78'h0, rsp_valid, rsp_err}, 80'h3);
    @(posedge clk) #1 mem_rvalid = 1'b1;
    @(negedge clk) check("to_late_rvalid", {78'h0, busy, rsp_valid}, 80'h0);
    @(posedge clk) #1 mem_rvalid = 1'b0;
`endif

    // One more access after the reset to confirm a clean restart
    access("lw",   0, F3_LW,  32'h0000_E004, 32'h0,         32'hCAFE_F00D, 1, 4'b1111, 32'h0,         32'hCAFE_F00D, 0, 0, 0);

    @(negedge clk) check("scoreboard_empty", 80'(exp_q.size()), 80'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory port.
- Accepts one load or store per handshake and computes byte enables and lane alignment for stores.
- Issues a req/gnt memory transaction, then waits for read data.
- Shifts and sign/zero-extends load data per funct3.
- Returns a response; holds busy high to stall the pipeline.
- Single outstanding access.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before an error response. Used only with LSU_TIMEOUT_EN.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes significant)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal funct3 or timeout
- busy  out  1  high in any state except IDLE
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - mem_req, mem_we, rsp_valid, rsp_err and busy are 0.
  - mem_be, mem_addr, mem_wdata and rsp_rdata are 0.
  - req_ready is 1.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On req_valid (req_ready=1), register we, funct3, addr[1:0] and computed be/wdata.
  - If the access is legal, go to REQ. Otherwise set rsp_err=1 and go to RESP; memory is never touched.
- Legality:
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Legal load funct3: 000, 001, 010, 100, 101.
  - Legal store funct3: 000, 001, 010.
- REQ:
  - mem_req=1, with address, we, be and wdata stable until mem_gnt.
  - On the mem_gnt cycle go to WAIT; mem_req drops the next cycle.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - On mem_rvalid, capture the result and go to RESP.
  - Loads: shifted = mem_rdata >> (8*addr[1:0]), then extend per funct3. Stores: rsp_rdata=0.
- RESP:
  - rsp_valid=1; outputs are held until rsp_ready, then return to IDLE.
  - The earliest new request is accepted the cycle after the handshake.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111; wdata unchanged.
- Load lanes: mem_be=1111 for all loads.
- Best-case latency, with mem_gnt and mem_rvalid each one cycle later:
  - Accept at cycle 0, REQ at 1, gnt at 1, rvalid at 2, rsp_valid at 3.
  - An illegal access gives rsp_valid at cycle 1.
- Reset mid-transaction: abandons immediately; no response is produced.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering WAIT and increments each WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A late mem_rvalid arriving in RESP or IDLE is ignored.
  - If mem_rvalid coincides with expiry, mem_rvalid wins.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Shared package (defines header):
  - funct3 codes LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3.
- One natural sub-module, lsu_align (combinational):
  - Inputs funct3, addr[1:0], wdata, rdata.
  - Outputs be, wdata_lanes, load_ext and misaligned.
- FSM, registers and timeout stay in lsu_ctrl.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80_22_33_44, gnt and rvalid immediate -> rsp_rdata=0xFFFFFF80, rsp_err=0, rsp_valid at cycle 3.
- LHU at 0x2002, rdata=0xBEEF_1234 -> rsp_rdata=0x0000BEEF; mem_be=1111; mem_addr=0x2000.
- SH at 0x3002, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; response has rsp_rdata=0.
- LW at 0x4001 -> no mem_req ever; rsp_valid at cycle 1 with rsp_err=1. Illegal load funct3=011 gives the same result.
- mem_gnt held low 5 cycles -> mem_req and all mem_* stable throughout. Then hold rsp_ready low 3 cycles -> rsp_valid and rsp_rdata held, req_ready=0, busy=1.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, rvalid never asserted -> rsp_err=1 after 4 WAIT cycles. Separately, assert rst_n=0 during WAIT -> immediate IDLE, no rsp_valid.
